uart_cmd_scheduler: RTL and testbench

//  Sits between the UART receiver/transmitter pair and the stopwatch/watch core.
//  - Decodes received ASCII bytes into one-cycle command pulses.
//  - Queues acknowledge bytes in a TX FIFO.
//  - Schedules that FIFO onto the single uart_tx using its start/busy/done handshake.
//  - Replaces direct rx->tx loopback; the transmitter is driven only by this block.

---
 rtl/uart_cmd_scheduler_pkg.sv | 58 +++++
 rtl/uart_cmd_scheduler_tx_fifo.sv | 74 +++++++
 rtl/uart_cmd_scheduler.sv | 162 ++++++++++++++++
 tb/tb_uart_cmd_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// uart_cmd_scheduler_pkg: ASCII constants, scheduler states and decode helpers
// Rev 1.0
// ============================================================================
package uart_cmd_scheduler_pkg;

   localparam logic [7:0] ASCII_ESC   = 8'h1B;
   localparam logic [7:0] ASCII_R_UP  = 8'h52;
   localparam logic [7:0] ASCII_R_LO  = 8'h72;
   localparam logic [7:0] ASCII_C_UP  = 8'h43;
   localparam logic [7:0] ASCII_C_LO  = 8'h63;
   localparam logic [7:0] ASCII_M_UP  = 8'h4D;
   localparam logic [7:0] ASCII_M_LO  = 8'h6D;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_EOL   = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_DONE = 2'd2
   } sched_state_e;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_RUN   = 3'd1,
      CMD_CLEAR = 3'd2,
      CMD_MODE  = 3'd3,
      CMD_ESC   = 3'd4
   } cmd_e;

   function automatic cmd_e decode_cmd(input logic [7:0] b);
      cmd_e c;
      case (b)
         ASCII_R_UP, ASCII_R_LO: c = CMD_RUN;
         ASCII_C_UP, ASCII_C_LO: c = CMD_CLEAR;
         ASCII_M_UP, ASCII_M_LO: c = CMD_MODE;
         ASCII_ESC:              c = CMD_ESC;
         default:                c = CMD_NONE;
      endcase
      return c;
   endfunction

   // Acknowledge is always the uppercase letter, '?' for anything unknown
   function automatic logic [7:0] ack_byte(input cmd_e c);
      logic [7:0] b;
      case (c)
         CMD_RUN:   b = ASCII_R_UP;
         CMD_CLEAR: b = ASCII_C_UP;
         CMD_MODE:  b = ASCII_M_UP;
         default:   b = ASCII_QMARK;
      endcase
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_scheduler_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo: synchronous byte FIFO with flush and free-entry count
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [7:0]                    push_data,
   input  logic                          pop,
   input  logic                          flush,
   output logic [7:0]                    head_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   free_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        push_ok;
   logic        pop_ok;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign free_cnt  = (AW+1)'(FIFO_DEPTH) - (wr_ptr_q - rd_ptr_q);
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   // Flush wins over a same-cycle push; a same-cycle pop has already read the head
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// uart_cmd_scheduler: decodes RX bytes into command pulses, queues acknowledges
// and schedules them onto uart_tx. Rev 1.0
// ============================================================================
module uart_cmd_scheduler
   import uart_cmd_scheduler_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter bit          ACK_EN     = 1'b1,
   parameter logic [7:0]  EOL_CHAR   = ASCII_EOL
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       cmd_run_stop,
   output logic       cmd_clear,
   output logic       cmd_mode,
   output logic       cmd_esc_rst,
   output logic       err_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   cmd_e         rx_cmd;
   logic         ack_req;
   logic         fifo_room;
   logic         cmd_run_stop_q, cmd_run_stop_d;
   logic         cmd_clear_q, cmd_clear_d;
   logic         cmd_mode_q, cmd_mode_d;
   logic         cmd_esc_rst_q, cmd_esc_rst_d;
   logic         err_overflow_q, err_overflow_d;
   logic         enq_q, enq_d;
   logic [7:0]   enq_byte_q, enq_byte_d;
   logic         eol_pend_q, eol_pend_d;
   sched_state_e state_q, state_d;
   logic         tx_start_q, tx_start_d;
   logic [7:0]   tx_data_q, tx_data_d;

   logic         fifo_push;
   logic [7:0]   fifo_push_data;
   logic         fifo_pop;
   logic [7:0]   fifo_head;
   logic         fifo_full;
   logic         fifo_empty;
   logic [AW:0]  fifo_free_cnt;

   // Both bytes of an acknowledge are admitted together or not at all
   always_comb begin
      rx_cmd         = decode_cmd(rx_data);
      ack_req        = rx_done && ACK_EN && (rx_cmd != CMD_ESC);
      fifo_room      = !fifo_full && (fifo_free_cnt >= (AW+1)'(2));
      cmd_run_stop_d = rx_done && (rx_cmd == CMD_RUN);
      cmd_clear_d    = rx_done && (rx_cmd == CMD_CLEAR);
      cmd_mode_d     = rx_done && (rx_cmd == CMD_MODE);
      cmd_esc_rst_d  = rx_done && (rx_cmd == CMD_ESC);
      err_overflow_d = ack_req && !fifo_room;
      enq_d          = ack_req && fifo_room;
      enq_byte_d     = enq_d ? ack_byte(rx_cmd) : enq_byte_q;
      eol_pend_d     = eol_pend_q;
      if (cmd_esc_rst_q) begin
         eol_pend_d = 1'b0;
      end else if (enq_q) begin
         eol_pend_d = 1'b1;
      end else if (eol_pend_q) begin
         eol_pend_d = 1'b0;
      end
   end

   assign fifo_push      = enq_q || eol_pend_q;
   assign fifo_push_data = enq_q ? enq_byte_q : EOL_CHAR;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .flush     (cmd_esc_rst_q),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .free_cnt  (fifo_free_cnt)
   );

   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      fifo_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !tx_busy) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A flush landing between IDLE and LOAD can leave nothing to send
            if (!fifo_empty && !tx_busy) begin
               fifo_pop   = 1'b1;
               tx_data_d  = fifo_head;
               tx_start_d = 1'b1;
               state_d    = ST_WAIT_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_run_stop_q <= 1'b0;
         cmd_clear_q    <= 1'b0;
         cmd_mode_q     <= 1'b0;
         cmd_esc_rst_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         enq_q          <= 1'b0;
         enq_byte_q     <= 8'h00;
         eol_pend_q     <= 1'b0;
         state_q        <= ST_IDLE;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
      end else begin
         cmd_run_stop_q <= cmd_run_stop_d;
         cmd_clear_q    <= cmd_clear_d;
         cmd_mode_q     <= cmd_mode_d;
         cmd_esc_rst_q  <= cmd_esc_rst_d;
         err_overflow_q <= err_overflow_d;
         enq_q          <= enq_d;
         enq_byte_q     <= enq_byte_d;
         eol_pend_q     <= eol_pend_d;
         state_q        <= state_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
      end
   end

   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign cmd_run_stop = cmd_run_stop_q;
   assign cmd_clear    = cmd_clear_q;
   assign cmd_mode     = cmd_mode_q;
   assign cmd_esc_rst  = cmd_esc_rst_q;
   assign err_overflow = err_overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_scheduler: directed self-checking bench with a uart_tx model
// Rev 1.0
// ============================================================================
module tb_uart_cmd_scheduler;

   localparam int FRAME = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_busy;
   logic       tx_done = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       cmd_run_stop, cmd_clear, cmd_mode, cmd_esc_rst, err_overflow;

   logic       m_busy = 1'b0;
   logic       force_busy = 1'b0;
   logic [4:0] vec;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] log_q[$];
   int         cyc = 0;
   int         last_done_cyc = -100;

   assign tx_busy = m_busy | force_busy;
   assign vec = {cmd_run_stop, cmd_clear, cmd_mode, cmd_esc_rst, err_overflow};

   always #5 clk = ~clk;

   uart_cmd_scheduler #(
      .FIFO_DEPTH (8),
      .ACK_EN     (1'b1),
      .EOL_CHAR   (8'h0A)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_done      (rx_done),
      .rx_data      (rx_data),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .cmd_run_stop (cmd_run_stop),
      .cmd_clear    (cmd_clear),
      .cmd_mode     (cmd_mode),
      .cmd_esc_rst  (cmd_esc_rst),
      .err_overflow (err_overflow)
   );

   // uart_tx model: busy for FRAME cycles after each start, then a done pulse
   initial begin
      int         cnt;
      logic [7:0] cur;
      cnt = 0;
      cur = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_busy  = 1'b0;
            tx_done = 1'b0;
            cnt     = 0;
         end else begin
            tx_done = 1'b0;
            if (tx_start) begin
               n_checks++;
               if (tx_busy || (cyc - last_done_cyc) < 2) begin
                  n_fail++;
                  $display("FAIL handshake: tx_start with busy=%0b gap=%0d, required busy=0 gap>=2",
                           tx_busy, cyc - last_done_cyc);
               end
               log_q.push_back(tx_data);
               cur    = tx_data;
               m_busy = 1'b1;
               cnt    = FRAME;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  n_checks++;
                  if (tx_data !== cur) begin
                     n_fail++;
                     $display("FAIL tx_data_hold: got %h at tx_done, required %h", tx_data, cur);
                  end
                  m_busy        = 1'b0;
                  tx_done       = 1'b1;
                  last_done_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic send_rx(input logic [7:0] b, output logic [4:0] v1, output logic [4:0] v2);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      v1 = vec;
      @(negedge clk);
      v2 = vec;
   endtask

   task automatic wait_log(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (log_q.size() >= n) break;
         @(negedge clk);
      end
      ok = (log_q.size() >= n);
   endtask

   task automatic test_reset();
      n_checks++;
      if (vec !== 5'b00000) begin
         n_fail++; $display("FAIL reset_cmds: got %b required 00000", vec);
      end
      n_checks++;
      if (tx_start !== 1'b0) begin
         n_fail++; $display("FAIL reset_tx_start: got %b required 0", tx_start);
      end
      n_checks++;
      if (tx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_tx_data: got %h required 00", tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++;
      if (log_q.size() !== 0) begin
         n_fail++; $display("FAIL reset_idle_tx: got %0d bytes required 0", log_q.size());
      end
   endtask

   task automatic test_ack(input string name, input logic [7:0] b,
                           input logic [4:0] exp_vec, input logic [7:0] exp_ack);
      logic [4:0] v1, v2;
      bit         ok;
      log_q.delete();
      send_rx(b, v1, v2);
      n_checks++;
      if (v1 !== exp_vec) begin
         n_fail++; $display("FAIL %s_pulse: got %b required %b", name, v1, exp_vec);
      end
      n_checks++;
      if (v2 !== 5'b00000) begin
         n_fail++; $display("FAIL %s_pulse_width: got %b required 00000", name, v2);
      end
      wait_log(2, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL %s_tx_timeout: got %0d bytes required 2", name, log_q.size());
      end else begin
         n_checks++;
         if (log_q[0] !== exp_ack) begin
            n_fail++; $display("FAIL %s_ack: got %h required %h", name, log_q[0], exp_ack);
         end
         n_checks++;
         if (log_q[1] !== 8'h0A) begin
            n_fail++; $display("FAIL %s_eol: got %h required 0a", name, log_q[1]);
         end
      end
      repeat (40) @(negedge clk);
      n_checks++;
      if (log_q.size() !== 2) begin
         n_fail++; $display("FAIL %s_count: got %0d bytes required 2", name, log_q.size());
      end
   endtask

   task automatic test_esc_flush();
      logic [4:0] v1, v2;
      bit         ok;
      log_q.delete();
      send_rx(8'h43, v1, v2);
      wait_log(1, 50, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL esc_first_start: got %0d bytes required 1", log_q.size());
      end
      send_rx(8'h4D, v1, v2);
      n_checks++;
      if (v1 !== 5'b00100) begin
         n_fail++; $display("FAIL esc_mode_pulse: got %b required 00100", v1);
      end
      repeat (2) @(negedge clk);
      send_rx(8'h1B, v1, v2);
      n_checks++;
      if (v1 !== 5'b00010) begin
         n_fail++; $display("FAIL esc_pulse: got %b required 00010", v1);
      end
      n_checks++;
      if (v2 !== 5'b00000) begin
         n_fail++; $display("FAIL esc_pulse_width: got %b required 00000", v2);
      end
      repeat (80) @(negedge clk);
      n_checks++;
      if (log_q.size() !== 1) begin
         n_fail++; $display("FAIL esc_flush_count: got %0d bytes required 1", log_q.size());
      end else begin
         n_checks++;
         if (log_q[0] !== 8'h43) begin
            n_fail++; $display("FAIL esc_inflight: got %h required 43", log_q[0]);
         end
      end
   endtask

   task automatic test_overflow_busy_hold();
      logic [7:0] cmds [5];
      logic [4:0] exp_v [5];
      logic [7:0] exp_tx [8];
      logic [4:0] v1, v2;
      bit         ok;
      bit         seen;
      cmds  = '{8'h52, 8'h63, 8'h4D, 8'h72, 8'h43};
      exp_v = '{5'b10000, 5'b01000, 5'b00100, 5'b10000, 5'b01001};
      exp_tx = '{8'h52, 8'h0A, 8'h43, 8'h0A, 8'h4D, 8'h0A, 8'h52, 8'h0A};
      log_q.delete();
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_rx(cmds[i], v1, v2);
         n_checks++;
         if (v1 !== exp_v[i]) begin
            n_fail++; $display("FAIL ovf_pulse_%0d: got %b required %b", i, v1, exp_v[i]);
         end
         n_checks++;
         if (v2 !== 5'b00000) begin
            n_fail++; $display("FAIL ovf_pulse_width_%0d: got %b required 00000", i, v2);
         end
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (log_q.size() !== 0) begin
         n_fail++; $display("FAIL busy_hold: got %0d starts required 0", log_q.size());
      end
      force_busy = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (tx_start) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL busy_release_start: got tx_start=0 required 1 within 2 clk");
      end
      wait_log(8, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL ovf_tx_timeout: got %0d bytes required 8", log_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_q[i] !== exp_tx[i]) begin
               n_fail++; $display("FAIL ovf_tx_%0d: got %h required %h", i, log_q[i], exp_tx[i]);
            end
         end
      end
      repeat (60) @(negedge clk);
      n_checks++;
      if (log_q.size() !== 8) begin
         n_fail++; $display("FAIL ovf_tx_count: got %0d bytes required 8", log_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [4:0] v1, v2;
      bit         ok;
      log_q.delete();
      send_rx(8'h52, v1, v2);
      wait_log(1, 50, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL rst_mid_start: got %0d bytes required 1", log_q.size());
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (vec !== 5'b00000) begin
         n_fail++; $display("FAIL rst_mid_cmds: got %b required 00000", vec);
      end
      n_checks++;
      if (tx_data !== 8'h00 || tx_start !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_tx: got data=%h start=%b required 00/0", tx_data, tx_start);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      log_q.delete();
      repeat (40) @(negedge clk);
      n_checks++;
      if (log_q.size() !== 0) begin
         n_fail++; $display("FAIL rst_mid_fifo_empty: got %0d starts required 0", log_q.size());
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_ack("run_lower", 8'h72, 5'b10000, 8'h52);
      test_ack("unknown",   8'h41, 5'b00000, 8'h3F);
      test_ack("clear_up",  8'h43, 5'b01000, 8'h43);
      test_ack("mode_lower", 8'h6D, 5'b00100, 8'h4D);
      test_esc_flush();
      test_overflow_busy_hold();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
